// File: rtl/multicycle_ctrl_seq_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle control sequencer.
//   state_t  - 4-bit sequencer state (also driven out on the debug port)
//   class_t  - instruction class produced by ctrl_decoder
//   OP_*/EXT_* opcode and extension field values
//   PC_SRC_*/WB_SEL_* mux select encodings
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WB = 4'd5,
        S_MEM_WR = 4'd6,
        S_BRANCH = 4'd7,
        S_JAL    = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_JAL,
        CLS_JUMP,
        CLS_BRANCH,
        CLS_HALT
    } class_t;

    localparam logic [3:0] OP_RTYPE   = 4'h0;
    localparam logic [3:0] OP_SPECIAL = 4'h4;
    localparam logic [3:0] OP_BCOND   = 4'hC;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_JCOND = 4'hC;

    localparam logic [1:0] PC_SRC_INC = 2'd0;  // PC + 1
    localparam logic [1:0] PC_SRC_REL = 2'd1;  // PC + sign-extended imm8
    localparam logic [1:0] PC_SRC_REG = 2'd2;  // register A

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    // States whose duration is set by the memory access timing.
    function automatic logic is_access(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_seq_decoder.sv
// ctrl_decoder: purely combinational instruction classifier.
//   op_code - IR[15:12]
//   ext_op  - IR[7:4]
//   cls     - instruction class selecting the post-DECODE state sequence
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [3:0] op_code,
    input  logic [3:0] ext_op,
    output class_t     cls
);

    always_comb begin
        cls = CLS_I;
        case (op_code)
            OP_RTYPE: cls = CLS_R;
            OP_SPECIAL: begin
                case (ext_op)
                    EXT_LOAD:  cls = CLS_LOAD;
                    EXT_STOR:  cls = CLS_STORE;
                    EXT_JAL:   cls = CLS_JAL;
                    EXT_JCOND: cls = CLS_JUMP;
                    // Unused special extensions fall back to an ALU operation.
                    default:   cls = CLS_R;
                endcase
            end
            OP_BCOND: cls = CLS_BRANCH;
            OP_HALT:  cls = CLS_HALT;
            default:  cls = CLS_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_seq.sv
// multicycle_ctrl_seq: multi-cycle control sequencer for the 16-bit processor.
// Fetches and latches an instruction, decodes it, then walks a per-class state
// sequence driving register-file, ALU, PC and dual-port memory controls.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   instruction           - memory port-B read data, latched into IR at end of FETCH
//   mem_ready             - access-complete strobe (only when USE_MEM_READY=1)
//   cond_met              - branch condition, used in BRANCH
//   stall                 - freeze state, counter and IR; suppress write/PC enables
//   reg_we, reg_waddr, reg_raddr_a, reg_raddr_b - register-file controls
//   op_code, ext_op, imm_high, imm_low          - IR fields
//   reg_or_imm, pc_en, pc_src, wb_sel           - datapath selects
//   mem_a_en, mem_a_we, mem_b_en                - memory port enables
//   halted, state                               - status / debug
module multicycle_ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int MEM_LATENCY   = 1,
    parameter int USE_MEM_READY = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       instruction,
    input  logic              mem_ready,
    input  logic              cond_met,
    input  logic              stall,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [REG_AW-1:0] reg_raddr_a,
    output logic [REG_AW-1:0] reg_raddr_b,
    output logic [3:0]        op_code,
    output logic [3:0]        ext_op,
    output logic [3:0]        imm_high,
    output logic [3:0]        imm_low,
    output logic              reg_or_imm,
    output logic              pc_en,
    output logic [1:0]        pc_src,
    output logic [1:0]        wb_sel,
    output logic              mem_a_en,
    output logic              mem_a_we,
    output logic              mem_b_en,
    output logic              halted,
    output logic [3:0]        state
);

    // The counter records cycles spent in the current access state; it is
    // zero on entry, so the fixed-latency exit lands on the (MEM_LATENCY-1)th
    // count, equivalent to a down-count from MEM_LATENCY-1 reaching zero.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t      cur;
    logic [3:0]  cnt;
    logic [15:0] ir;
    class_t      cls;
    logic        acc_done;

    ctrl_decoder u_decoder (
        .op_code (ir[15:12]),
        .ext_op  (ir[7:4]),
        .cls     (cls)
    );

    assign acc_done = (USE_MEM_READY != 0) ? mem_ready : (cnt == LAST_CNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            cur <= S_FETCH;
            cnt <= 4'd0;
            ir  <= 16'd0;
        end else if (!stall) begin
            case (cur)
                S_FETCH: begin
                    if (acc_done) begin
                        ir  <= instruction;
                        cur <= S_DECODE;
                        cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_DECODE: begin
                    cnt <= 4'd0;
                    case (cls)
                        CLS_R:      cur <= S_EXEC_R;
                        CLS_I:      cur <= S_EXEC_I;
                        CLS_LOAD:   cur <= S_MEM_RD;
                        CLS_STORE:  cur <= S_MEM_WR;
                        CLS_JAL:    cur <= S_JAL;
                        CLS_JUMP:   cur <= S_JUMP;
                        CLS_BRANCH: cur <= S_BRANCH;
                        CLS_HALT:   cur <= S_HALT;
                    endcase
                end
                S_MEM_RD: begin
                    if (acc_done) begin
                        cur <= S_MEM_WB;
                        cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_MEM_WR: begin
                    if (acc_done) begin
                        cur <= S_FETCH;
                        cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_HALT: begin
                    cur <= S_HALT;
                end
                default: begin
                    // Single-cycle execute states all return to FETCH.
                    cur <= S_FETCH;
                    cnt <= 4'd0;
                end
            endcase
        end
    end

    // Moore decode of the registered state. Stall and reset gate the
    // enables combinationally so that no write or PC update lands on a
    // stalled edge or on the edge that takes reset.
    always_comb begin
        reg_we     = 1'b0;
        reg_or_imm = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PC_SRC_INC;
        wb_sel     = WB_SEL_ALU;
        mem_a_en   = 1'b0;
        mem_a_we   = 1'b0;
        mem_b_en   = 1'b0;
        halted     = 1'b0;
        case (cur)
            S_FETCH:  mem_b_en = 1'b1;
            S_EXEC_R: begin
                reg_we = 1'b1;
                pc_en  = 1'b1;
            end
            S_EXEC_I: begin
                reg_we     = 1'b1;
                reg_or_imm = 1'b1;
                pc_en      = 1'b1;
            end
            S_MEM_RD: mem_a_en = 1'b1;
            S_MEM_WB: begin
                reg_we = 1'b1;
                wb_sel = WB_SEL_MEM;
                pc_en  = 1'b1;
            end
            S_MEM_WR: begin
                mem_a_en = 1'b1;
                mem_a_we = 1'b1;
                pc_en    = acc_done;
            end
            S_BRANCH: begin
                pc_en  = 1'b1;
                pc_src = cond_met ? PC_SRC_REL : PC_SRC_INC;
            end
            S_JAL: begin
                reg_we = 1'b1;
                wb_sel = WB_SEL_LINK;
                pc_en  = 1'b1;
                pc_src = PC_SRC_REG;
            end
            S_JUMP: begin
                pc_en  = 1'b1;
                pc_src = PC_SRC_REG;
            end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
        if (stall) begin
            reg_we   = 1'b0;
            pc_en    = 1'b0;
            mem_a_we = 1'b0;
        end
        if (reset) begin
            reg_we     = 1'b0;
            reg_or_imm = 1'b0;
            pc_en      = 1'b0;
            pc_src     = PC_SRC_INC;
            wb_sel     = WB_SEL_ALU;
            mem_a_en   = 1'b0;
            mem_a_we   = 1'b0;
            mem_b_en   = 1'b0;
            halted     = 1'b0;
        end
    end

    assign reg_waddr   = REG_AW'(ir[11:8]);
    assign reg_raddr_a = REG_AW'(ir[11:8]);
    assign reg_raddr_b = REG_AW'(ir[3:0]);
    assign op_code     = ir[15:12];
    assign ext_op      = ir[7:4];
    assign imm_high    = ir[7:4];
    assign imm_low     = ir[3:0];
    assign state       = cur;

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Bench for multicycle_ctrl_seq. Three instances: defaults (latency 1),
// fixed latency 3, and ready-handshake mode. Each is exercised in turn while
// the others sit in reset; every cycle the selected instance's outputs are
// compared against a phase-list reference model built from the instruction.
module tb_multicycle_ctrl_seq;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       reg_we;
        logic [4:0] reg_waddr;
        logic [4:0] reg_raddr_a;
        logic [4:0] reg_raddr_b;
        logic [3:0] op_code;
        logic [3:0] ext_op;
        logic [3:0] imm_high;
        logic [3:0] imm_low;
        logic       reg_or_imm;
        logic       pc_en;
        logic [1:0] pc_src;
        logic [1:0] wb_sel;
        logic       mem_a_en;
        logic       mem_a_we;
        logic       mem_b_en;
        logic       halted;
        logic [3:0] state;
    } obs_t;

    logic        clock = 1'b0;
    logic [2:0]  rst_v;
    logic [15:0] instruction;
    logic        mem_ready;
    logic        cond_met;
    logic        stall;
    obs_t        obs [3];

    int          n_checks = 0;
    int          n_errors = 0;
    int          sel;
    int          cyc = 0;
    logic [15:0] ir_m;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 1) ? 3 : 1;
        localparam int RDY = (g == 2) ? 1 : 0;
        logic       reg_we, reg_or_imm, pc_en, mem_a_en, mem_a_we, mem_b_en, halted;
        logic [4:0] reg_waddr, reg_raddr_a, reg_raddr_b;
        logic [3:0] op_code, ext_op, imm_high, imm_low, state;
        logic [1:0] pc_src, wb_sel;

        multicycle_ctrl_seq #(
            .REG_AW(5), .MEM_LATENCY(LAT), .USE_MEM_READY(RDY)
        ) dut (
            .clock(clock), .reset(rst_v[g]), .instruction(instruction),
            .mem_ready(mem_ready), .cond_met(cond_met), .stall(stall),
            .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_raddr_a(reg_raddr_a),
            .reg_raddr_b(reg_raddr_b), .op_code(op_code), .ext_op(ext_op),
            .imm_high(imm_high), .imm_low(imm_low), .reg_or_imm(reg_or_imm),
            .pc_en(pc_en), .pc_src(pc_src), .wb_sel(wb_sel), .mem_a_en(mem_a_en),
            .mem_a_we(mem_a_we), .mem_b_en(mem_b_en), .halted(halted), .state(state)
        );

        assign obs[g] = obs_t'({reg_we, reg_waddr, reg_raddr_a, reg_raddr_b,
                                op_code, ext_op, imm_high, imm_low, reg_or_imm,
                                pc_en, pc_src, wb_sel, mem_a_en, mem_a_we,
                                mem_b_en, halted, state});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected outputs from the state table: the fields come from the latched
    // instruction, enables from the state, stall suppresses writes and PC
    // loads, and an asserted reset clears every control output.
    function automatic obs_t expect_obs(state_t s, bit last, bit stl, bit rst,
                                        logic [15:0] ir, bit cond);
        obs_t e;
        e = '0;
        e.reg_waddr   = {1'b0, ir[11:8]};
        e.reg_raddr_a = {1'b0, ir[11:8]};
        e.reg_raddr_b = {1'b0, ir[3:0]};
        e.op_code     = ir[15:12];
        e.ext_op      = ir[7:4];
        e.imm_high    = ir[7:4];
        e.imm_low     = ir[3:0];
        e.state       = s;
        if (!rst) begin
            case (s)
                S_FETCH:  e.mem_b_en = 1'b1;
                S_EXEC_R: begin e.reg_we = 1'b1; e.pc_en = 1'b1; end
                S_EXEC_I: begin e.reg_we = 1'b1; e.pc_en = 1'b1; e.reg_or_imm = 1'b1; end
                S_MEM_RD: e.mem_a_en = 1'b1;
                S_MEM_WB: begin e.reg_we = 1'b1; e.wb_sel = 2'd1; e.pc_en = 1'b1; end
                S_MEM_WR: begin e.mem_a_en = 1'b1; e.mem_a_we = 1'b1; e.pc_en = last; end
                S_BRANCH: begin e.pc_en = 1'b1; e.pc_src = cond ? 2'd1 : 2'd0; end
                S_JAL:    begin e.reg_we = 1'b1; e.wb_sel = 2'd2; e.pc_en = 1'b1; e.pc_src = 2'd2; end
                S_JUMP:   begin e.pc_en = 1'b1; e.pc_src = 2'd2; end
                S_HALT:   e.halted = 1'b1;
                default:  ;
            endcase
            if (stl) begin
                e.reg_we   = 1'b0;
                e.pc_en    = 1'b0;
                e.mem_a_we = 1'b0;
            end
        end
        return e;
    endfunction

    // Assert reset for two cycles starting from state cur_s; returns with
    // reset still high, ready for the next instruction to release it.
    task automatic reset_seq(input state_t cur_s);
        @(negedge clock);
        rst_v       = 3'b111;
        stall       = 1'($urandom);
        cond_met    = 1'($urandom);
        mem_ready   = 1'($urandom);
        instruction = 16'($urandom);
        #1;
        check($sformatf("rst_assert_%s@%0d", cur_s.name(), cyc), 64'(obs[sel]),
              64'(expect_obs(cur_s, 1'b0, stall, 1'b1, ir_m, cond_met)));
        ir_m = 16'h0000;
        cyc++;
        @(negedge clock);
        #1;
        check($sformatf("rst_state@%0d", cyc), 64'(obs[sel]), 64'(obs_t'('0)));
        cyc++;
    endtask

    // Runs one instruction cycle by cycle. fetch_len forces the FETCH length
    // in ready mode; abort_rd asserts reset partway through MEM_RD.
    task automatic run_instr(input logic [15:0] instr, input bit allow_stall,
                             input bit stall_wb, input bit abort_rd,
                             input int halt_cycles, input int fetch_len);
        state_t ph_s [$];
        int     ph_n [$];
        int     lat;
        bit     rdy;
        logic [3:0] op, ext;
        bit     wb_stalled;
        lat = (sel == 1) ? 3 : 1;
        rdy = (sel == 2);
        op  = instr[15:12];
        ext = instr[7:4];
        wb_stalled = 1'b0;

        ph_s.push_back(S_FETCH);
        ph_n.push_back(fetch_len > 0 ? fetch_len : (rdy ? int'($urandom_range(1, 5)) : lat));
        ph_s.push_back(S_DECODE);
        ph_n.push_back(1);
        if (op == 4'hF) begin
            ph_s.push_back(S_HALT);      ph_n.push_back(halt_cycles);
        end else if (op == 4'hC) begin
            ph_s.push_back(S_BRANCH);    ph_n.push_back(1);
        end else if (op == 4'h4 && ext == 4'h0) begin
            ph_s.push_back(S_MEM_RD);
            ph_n.push_back(rdy ? int'($urandom_range(1, 5)) : lat);
            ph_s.push_back(S_MEM_WB);    ph_n.push_back(1);
        end else if (op == 4'h4 && ext == 4'h4) begin
            ph_s.push_back(S_MEM_WR);
            ph_n.push_back(rdy ? int'($urandom_range(1, 5)) : lat);
        end else if (op == 4'h4 && ext == 4'h8) begin
            ph_s.push_back(S_JAL);       ph_n.push_back(1);
        end else if (op == 4'h4 && ext == 4'hC) begin
            ph_s.push_back(S_JUMP);      ph_n.push_back(1);
        end else if (op == 4'h0 || op == 4'h4) begin
            ph_s.push_back(S_EXEC_R);    ph_n.push_back(1);
        end else begin
            ph_s.push_back(S_EXEC_I);    ph_n.push_back(1);
        end

        for (int i = 0; i < ph_s.size(); i++) begin
            for (int k = 0; k < ph_n[i]; k++) begin
                bit last, stl, done;
                state_t s;
                s    = ph_s[i];
                last = (k == ph_n[i] - 1);
                if (abort_rd && s == S_MEM_RD && k == ((ph_n[i] > 1) ? 1 : 0)) begin
                    reset_seq(S_MEM_RD);
                    return;
                end
                done = 1'b0;
                while (!done) begin
                    @(negedge clock);
                    rst_v[sel] = 1'b0;
                    stl = allow_stall && (s != S_HALT) && ($urandom_range(0, 5) == 0);
                    if (stall_wb && s == S_MEM_WB && !wb_stalled) begin
                        stl = 1'b1;
                        wb_stalled = 1'b1;
                    end
                    stall       = stl;
                    cond_met    = 1'($urandom);
                    instruction = (s == S_FETCH && last && !stl) ? instr : 16'($urandom);
                    if (rdy && is_access(s) && !stl) mem_ready = last;
                    else                             mem_ready = 1'($urandom);
                    #1;
                    check($sformatf("%s@%0d", s.name(), cyc), 64'(obs[sel]),
                          64'(expect_obs(s, last, stl, 1'b0, ir_m, cond_met)));
                    cyc++;
                    done = !stl;
                end
                if (s == S_FETCH && last) ir_m = instr;
            end
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        logic [3:0]  ext_tab [5];
        ext_tab = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h3};
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0: begin
                r[15:12] = 4'h4;
                r[7:4]   = ext_tab[$urandom_range(0, 4)];
            end
            1: r[15:12] = 4'hC;
            default: if (r[15:12] == 4'hF) r[15:12] = 4'h0;
        endcase
        return r;
    endfunction

    initial begin
        rst_v       = 3'b111;
        stall       = 1'b0;
        cond_met    = 1'b0;
        mem_ready   = 1'b0;
        instruction = 16'h0000;
        ir_m        = 16'h0000;
        for (int s = 0; s < 3; s++) begin
            sel  = s;
            ir_m = 16'h0000;
            reset_seq(S_FETCH);
            case (s)
                0: begin
                    run_instr(16'h0052, 1'b0, 1'b0, 1'b0, 0, 0);
                    run_instr(16'h4203, 1'b0, 1'b0, 1'b0, 0, 0);
                end
                1: begin
                    run_instr(16'h4243, 1'b0, 1'b0, 1'b0, 0, 0);
                    run_instr(16'h4203, 1'b0, 1'b1, 1'b0, 0, 0);
                end
                default: begin
                    run_instr(16'hC205, 1'b0, 1'b0, 1'b0, 0, 5);
                    run_instr(16'h4203, 1'b0, 1'b1, 1'b0, 0, 0);
                end
            endcase
            for (int n = 0; n < 40; n++) run_instr(rand_instr(), 1'b1, 1'b0, 1'b0, 0, 0);
            run_instr(16'h4105, 1'b1, 1'b0, 1'b1, 0, 0);
            run_instr(rand_instr(), 1'b1, 1'b0, 1'b0, 0, 0);
            run_instr(16'hFFFF, 1'b1, 1'b0, 1'b0, 20, 0);
            reset_seq(S_HALT);
            run_instr(16'h0052, 1'b1, 1'b0, 1'b0, 0, 0);
            rst_v = 3'b111;
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
